// File: rtl/cpu_sequencer.sv
// Fetch/execute control stage for the 4-bit minicpu datapath.
// Optional HLT opcode and HALT state enabled by defining SEQ_HALT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

module cpu_sequencer #(
  parameter int DW = `DATA_WIDTH,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_en,
  output logic          imem_req,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_data,
  input  logic [DW-1:0] pc_in,
  input  logic          alu_carry,
  output logic [DW-1:0] pc_next,
  output logic [DW-1:0] imm,
  output logic [1:0]    src_sel,
  output logic          ld_a_n,
  output logic          ld_b_n,
  output logic          ld_out_n,
  output logic          ld_pc_n,
  output logic          carry
);

`ifdef SEQ_HALT_EN
  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC, HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC
  } state_t;
`endif

  state_t        state, state_nx;
  logic [IW-1:0] instr;
  logic [3:0]    opc;
  logic          sel_a, sel_b, sel_out;
  logic          is_add, is_jnc, is_jmp, is_hlt;

  assign opc = 4'(instr[IW-1:DW]);
  assign imm = instr[DW-1:0];

  always_comb begin
    src_sel = 2'b11;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    sel_out = 1'b0;
    is_add  = 1'b0;
    is_jnc  = 1'b0;
    is_jmp  = 1'b0;
    is_hlt  = 1'b0;
    unique case (opc)
      4'h0: begin src_sel = 2'b00; sel_a = 1'b1; is_add = 1'b1; end
      4'h1: begin src_sel = 2'b01; sel_a = 1'b1; end
      4'h2: begin src_sel = 2'b10; sel_a = 1'b1; end
      4'h3: begin src_sel = 2'b11; sel_a = 1'b1; end
      4'h4: begin src_sel = 2'b00; sel_b = 1'b1; end
      4'h5: begin src_sel = 2'b01; sel_b = 1'b1; is_add = 1'b1; end
      4'h6: begin src_sel = 2'b10; sel_b = 1'b1; end
      4'h7: begin src_sel = 2'b11; sel_b = 1'b1; end
      4'h9: begin src_sel = 2'b01; sel_out = 1'b1; end
      4'hb: begin src_sel = 2'b11; sel_out = 1'b1; end
      4'he: is_jnc = 1'b1;
      4'hf: is_jmp = 1'b1;
`ifdef SEQ_HALT_EN
      4'h8: is_hlt = 1'b1;
`endif
      default: ;
    endcase
  end

  // JNC looks at the carry left by the previous instruction
  assign pc_next = (is_jmp || (is_jnc && !carry)) ? imm
                                                  : pc_in + DW'(1);

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ld_a_n   = 1'b1;
    ld_b_n   = 1'b1;
    ld_out_n = 1'b1;
    ld_pc_n  = 1'b1;
    unique case (state)
      IDLE: if (step_en) state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_nx = EXEC;
      end
      EXEC: begin
        ld_a_n   = ~sel_a;
        ld_b_n   = ~sel_b;
        ld_out_n = ~sel_out;
        ld_pc_n  = is_hlt;
`ifdef SEQ_HALT_EN
        state_nx = is_hlt ? HALT : IDLE;
`else
        state_nx = IDLE;
`endif
      end
`ifdef SEQ_HALT_EN
      HALT: state_nx = HALT;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      instr <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_valid) instr <= imem_data;
      if (state == EXEC) carry <= is_add ? alu_carry : 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer.
// Table of instruction vectors plus reset and halt sequences.
`timescale 1ns/1ps

module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       step_en;
  logic       imem_req;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [3:0] pc_in;
  logic       alu_carry;
  logic [3:0] pc_next;
  logic [3:0] imm;
  logic [1:0] src_sel;
  logic       ld_a_n, ld_b_n, ld_out_n, ld_pc_n;
  logic       carry;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .step_en(step_en),
    .imem_req(imem_req), .imem_valid(imem_valid),
    .imem_data(imem_data), .pc_in(pc_in),
    .alu_carry(alu_carry), .pc_next(pc_next), .imm(imm),
    .src_sel(src_sel), .ld_a_n(ld_a_n), .ld_b_n(ld_b_n),
    .ld_out_n(ld_out_n), .ld_pc_n(ld_pc_n), .carry(carry)
  );

  always #5 clk = ~clk;

  wire [3:0] stb = {ld_a_n, ld_b_n, ld_out_n, ld_pc_n};

  typedef struct {
    logic [7:0] instr;
    logic [3:0] pc;
    logic       ac;
    int         wt;
    logic       drop;
    logic [1:0] src;
    logic [3:0] stb;
    logic [3:0] pcn;
    logic       cy;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string nm, logic [15:0] got,
                              logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   cyc;
    bit   ok;
    sb.push_back(v);
    step_en    = 1'b1;
    pc_in      = v.pc;
    alu_carry  = v.ac;
    imem_valid = 1'b0;
    cyc = 0;
    ok  = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      ok = imem_req;
    end
    e = sb.pop_front();
    if (!ok) begin
      chk($sformatf("v%0d fetch_timeout", idx), 16'(imem_req), 16'd1);
      return;
    end
    chk($sformatf("v%0d fetch_lat", idx), 16'(cyc), 16'd1);
    if (v.drop) step_en = 1'b0;
    for (int w = 0; w < v.wt; w++) begin
      chk($sformatf("v%0d wait_req", idx), 16'(imem_req), 16'd1);
      chk($sformatf("v%0d wait_stb", idx), 16'(stb), 16'hf);
      @(negedge clk);
      cyc++;
    end
    imem_data  = v.instr;
    imem_valid = 1'b1;
    @(negedge clk);
    cyc++;
    chk($sformatf("v%0d exec_lat", idx), 16'(cyc), 16'(e.wt + 2));
    chk($sformatf("v%0d src_sel", idx), 16'(src_sel), 16'(e.src));
    chk($sformatf("v%0d strobes", idx), 16'(stb), 16'(e.stb));
    chk($sformatf("v%0d pc_next", idx), 16'(pc_next), 16'(e.pcn));
    chk($sformatf("v%0d imm", idx), 16'(imm), 16'(e.instr[3:0]));
    chk($sformatf("v%0d exec_req", idx), 16'(imem_req), 16'd0);
    step_en    = 1'b0;
    imem_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d carry", idx), 16'(carry), 16'(e.cy));
    chk($sformatf("v%0d idle_stb", idx), 16'(stb), 16'hf);
    @(negedge clk);
    chk($sformatf("v%0d idle_req", idx), 16'(imem_req), 16'd0);
  endtask

  initial begin
    vec_t add1;
    bit   ok;
    // instr, pc, ac, wt, drop, src, {a,b,out,pc}, pc_next, carry
    vt.push_back('{8'h35, 4'h3, 1'b0, 0, 1'b0, 2'b11, 4'b0110, 4'h4, 1'b0});
    vt.push_back('{8'h0f, 4'h0, 1'b1, 2, 1'b0, 2'b00, 4'b0110, 4'h1, 1'b1});
    vt.push_back('{8'he7, 4'h1, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h2, 1'b0});
    vt.push_back('{8'h0f, 4'h2, 1'b0, 0, 1'b0, 2'b00, 4'b0110, 4'h3, 1'b0});
    vt.push_back('{8'he7, 4'h3, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h7, 1'b0});
    vt.push_back('{8'h5a, 4'h7, 1'b1, 0, 1'b0, 2'b01, 4'b1010, 4'h8, 1'b1});
    vt.push_back('{8'h35, 4'h8, 1'b1, 0, 1'b0, 2'b11, 4'b0110, 4'h9, 1'b0});
    vt.push_back('{8'h90, 4'hf, 1'b0, 5, 1'b1, 2'b01, 4'b1100, 4'h0, 1'b0});
    vt.push_back('{8'h14, 4'h0, 1'b0, 0, 1'b0, 2'b01, 4'b0110, 4'h1, 1'b0});
    vt.push_back('{8'h23, 4'h1, 1'b0, 0, 1'b0, 2'b10, 4'b0110, 4'h2, 1'b0});
    vt.push_back('{8'h40, 4'h2, 1'b0, 0, 1'b0, 2'b00, 4'b1010, 4'h3, 1'b0});
    vt.push_back('{8'h62, 4'h3, 1'b0, 0, 1'b0, 2'b10, 4'b1010, 4'h4, 1'b0});
    vt.push_back('{8'h71, 4'h4, 1'b0, 0, 1'b0, 2'b11, 4'b1010, 4'h5, 1'b0});
    vt.push_back('{8'hb6, 4'h5, 1'b0, 0, 1'b0, 2'b11, 4'b1100, 4'h6, 1'b0});
    vt.push_back('{8'hf9, 4'h4, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h9, 1'b0});
    vt.push_back('{8'hc3, 4'h5, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h6, 1'b0});
    vt.push_back('{8'h5f, 4'h6, 1'b1, 1, 1'b0, 2'b01, 4'b1010, 4'h7, 1'b1});
    vt.push_back('{8'hf2, 4'h7, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h2, 1'b0});
    vt.push_back('{8'he5, 4'h2, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h5, 1'b0});
`ifndef SEQ_HALT_EN
    vt.push_back('{8'h80, 4'h3, 1'b0, 0, 1'b0, 2'b11, 4'b1110, 4'h4, 1'b0});
`endif

    reset      = 1'b0;
    step_en    = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 8'h35;
    pc_in      = 4'h0;
    alu_carry  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stb", 16'(stb), 16'hf);
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_carry", 16'(carry), 16'd0);
    chk("rst_src", 16'(src_sel), 16'd0);
    chk("rst_imm", 16'(imm), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_fetch_req", 16'(imem_req), 16'd1);
    chk("rel_fetch_stb", 16'(stb), 16'hf);
    reset      = 1'b0;
    step_en    = 1'b0;
    imem_valid = 1'b0;
    #1;
    chk("fetch_rst_req", 16'(imem_req), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_hold_req", 16'(imem_req), 16'd0);

    foreach (vt[i]) run_vec(vt[i], i);

    add1 = '{8'h01, 4'h0, 1'b1, 0, 1'b0, 2'b00, 4'b0110, 4'h1, 1'b1};
    run_vec(add1, 100);
    step_en = 1'b1;
    pc_in   = 4'h1;
    ok = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      ok = imem_req;
    end
    chk("jmp_fetch", 16'(ok), 16'd1);
    step_en    = 1'b0;
    imem_data  = 8'hf9;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("jmp_ld_pc", 16'(ld_pc_n), 16'd0);
    chk("jmp_pc_next", 16'(pc_next), 16'h9);
    chk("jmp_carry_pre", 16'(carry), 16'd1);
    reset = 1'b0;
    #1;
    chk("jmp_rst_ld_pc", 16'(ld_pc_n), 16'd1);
    chk("jmp_rst_stb", 16'(stb), 16'hf);
    chk("jmp_rst_carry", 16'(carry), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_stb", 16'(stb), 16'hf);
      chk("post_rst_req", 16'(imem_req), 16'd0);
    end

`ifdef SEQ_HALT_EN
    step_en = 1'b1;
    pc_in   = 4'h3;
    ok = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      ok = imem_req;
    end
    chk("hlt_fetch", 16'(ok), 16'd1);
    imem_data  = 8'h80;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("hlt_exec_stb", 16'(stb), 16'hf);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_req", 16'(imem_req), 16'd0);
      chk("halt_stb", 16'(stb), 16'hf);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("halt_exit_req", 16'(imem_req), 16'd1);
    step_en = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
